seq_shifter: RTL and testbench

SEQ_SHIFTER -- requirements
Module: seq_shifter

---
 rtl/seq_shifter_if.sv | 34 +++
 rtl/seq_shifter.sv | 126 ++++++++++++
 tb/tb_seq_shifter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_shifter_if.sv
// seq_shifter_if
// Groups the request and result handshakes of the sequential shifter.
//   in_valid  : request present (master -> slave)
//   in_ready  : shifter can accept a request (slave -> master)
//   in_a      : operand
//   in_shamt  : shift amount, $clog2(WIDTH) bits
//   in_op     : 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others pass-through
//   out_valid : result available (slave -> master)
//   out_ready : consumer accepts the result (master -> slave)
//   out_r     : result
interface seq_shifter_if #(
  parameter int WIDTH = 32
) ();
  localparam int SW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [SW-1:0]    in_shamt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_r;

  modport master (
    output in_valid, in_a, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_r
  );

  modport slave (
    input  in_valid, in_a, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_r
  );
endinterface

// File: rtl/seq_shifter.sv
// seq_shifter
// Multi-cycle barrel shifter: a request is latched in IDLE, shifted at most
// STEP bit positions per cycle in SHIFT, and the final result is presented
// in DONE until the consumer takes it.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   bus   : request/result handshake (seq_shifter_if.slave)
//   busy  : high whenever the FSM is not in IDLE
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic           clk,
  input  logic           rst,
  seq_shifter_if.slave   bus,
  output logic           busy
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [SW:0] STEP_W  = (SW+1)'(STEP);
  localparam logic [SW:0] WIDTH_W = (SW+1)'(WIDTH);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [SW-1:0]    remain_q, remain_d;
  logic [2:0]       op_q, op_d;
  logic [SW-1:0]    stepAmt;
  logic [WIDTH-1:0] stepped;

  // Distance for this cycle: the full step unless fewer positions remain.
  // The comparison is one bit wider so STEP == WIDTH stays representable.
  always_comb begin
    stepAmt = remain_q;
    if ({1'b0, remain_q} >= STEP_W) begin
      stepAmt = STEP_W[SW-1:0];
    end
  end

  // One partial shift of the working register. An arithmetic right shift
  // keeps the MSB, so every step refills with the original sign bit.
  always_comb begin
    stepped = work_q;
    case (op_q)
      OP_SLL: stepped = work_q << stepAmt;
      OP_SRL: stepped = work_q >> stepAmt;
      OP_SRA: stepped = $unsigned($signed(work_q) >>> stepAmt);
      OP_ROL: stepped = (work_q << stepAmt) | (work_q >> (WIDTH_W - {1'b0, stepAmt}));
      OP_ROR: stepped = (work_q >> stepAmt) | (work_q << (WIDTH_W - {1'b0, stepAmt}));
      default: stepped = work_q;
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      work_q   <= '0;
      res_q    <= '0;
      remain_q <= '0;
      op_q     <= 3'b000;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      res_q    <= res_d;
      remain_q <= remain_d;
      op_q     <= op_d;
    end
  end

  // Next-state logic. The result register only changes when entering DONE,
  // so out_r is stable in DONE and keeps its last value elsewhere.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    res_d    = res_q;
    remain_d = remain_q;
    op_d     = op_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d   = bus.in_a;
          op_d     = bus.in_op;
          remain_d = bus.in_shamt;
          if ((bus.in_shamt == '0) || (bus.in_op > OP_ROR)) begin
            res_d   = bus.in_a;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d   = stepped;
        remain_d = remain_q - stepAmt;
        if (remain_q == stepAmt) begin
          res_d   = stepped;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_r     = res_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter
// Directed and swept checks of seq_shifter (WIDTH=32, STEP=4) against a
// transaction-level model that computes each result in one step and
// predicts handshake timing from the shift amount.
module tb_seq_shifter;
  localparam int WIDTH = 32;
  localparam int STEP  = 4;

  logic clk;
  logic rst;
  logic busy;
  int   total;
  int   bad;

  seq_shifter_if #(.WIDTH(WIDTH)) bus ();

  seq_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Overall time bound so the run can never hang.
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Whole-operation result from plain arithmetic.
  function automatic logic [31:0] golden(input logic [31:0] a, input logic [2:0] op, input int s);
    logic [31:0] r;
    case (op)
      3'd0: r = a << s;
      3'd1: r = a >> s;
      3'd2: r = $unsigned($signed(a) >>> s);
      3'd3: r = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
      3'd4: r = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
      default: r = a;
    endcase
    return r;
  endfunction

  // Rising edges after the accepting edge until the result is shown.
  function automatic int modelLat(input int s, input logic [2:0] op);
    if (s == 0 || op > 3'd4) return 0;
    return (s + STEP - 1) / STEP;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Transaction model: tracks whether an operation is in flight, how many
  // edges remain before its result appears, and the value out_r holds.
  logic        mBusy;
  int          mLeft;
  logic [31:0] mOut;
  logic [31:0] mPend;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mBusy <= 1'b0;
      mLeft <= 0;
      mOut  <= '0;
      mPend <= '0;
    end else if (!mBusy) begin
      if (bus.in_valid) begin
        mBusy <= 1'b1;
        mPend <= golden(bus.in_a, bus.in_op, int'(bus.in_shamt));
        mLeft <= modelLat(int'(bus.in_shamt), bus.in_op);
        if (modelLat(int'(bus.in_shamt), bus.in_op) == 0) begin
          mOut <= golden(bus.in_a, bus.in_op, int'(bus.in_shamt));
        end
      end
    end else if (mLeft > 0) begin
      mLeft <= mLeft - 1;
      if (mLeft == 1) mOut <= mPend;
    end else if (bus.out_ready) begin
      mBusy <= 1'b0;
    end
  end

  // Every-cycle comparison against the model while out of reset.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        checkOutput("in_ready", {31'b0, bus.in_ready}, {31'b0, !mBusy});
        checkOutput("busy", {31'b0, busy}, {31'b0, mBusy});
        checkOutput("out_valid", {31'b0, bus.out_valid}, {31'b0, (mBusy && mLeft == 0)});
        if (mBusy && mLeft == 0) checkOutput("out_r", bus.out_r, mOut);
      end
    end
  end

  // Issue one request, measure latency, check the result, optionally hold
  // the result under backpressure while poking the input side, then release.
  task automatic applyStimulus(input logic [31:0] a, input logic [4:0] s, input logic [2:0] op,
                               input logic [31:0] expR, input int expLat, input int hold,
                               input string tag);
    int lat;
    @(negedge clk);
    bus.in_a     = a;
    bus.in_shamt = s;
    bus.in_op    = op;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = $urandom;
    bus.in_shamt = 5'($urandom_range(31));
    bus.in_op    = 3'($urandom_range(7));
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_res"}, bus.out_r, expR);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = $urandom;
      bus.in_shamt = 5'($urandom_range(31));
      bus.in_op    = 3'($urandom_range(7));
    end
    if (hold > 0) begin
      checkOutput({tag, "_held"}, bus.out_r, expR);
      checkOutput({tag, "_noready"}, {31'b0, bus.in_ready}, 32'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] sweepA;
    int          s;
    total         = 0;
    bad           = 0;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_shamt  = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;

    // Pin the model itself with hand-computed values.
    checkOutput("model_sra", golden(32'h80000010, 3'd2, 13), 32'hFFFC0000);
    checkOutput("model_ror", golden(32'h0000000F, 3'd4, 4), 32'hF0000000);
    checkOutput("model_rol", golden(32'h80000001, 3'd3, 1), 32'h00000003);
    checkOutput("model_lat31", 32'(modelLat(31, 3'd0)), 32'd8);

    // Reset state, observed while reset is held.
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_out_r", bus.out_r, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(32'h80000010, 5'd13, 3'd2, 32'hFFFC0000, 4, 0, "sra13");
    applyStimulus(32'h0000000F, 5'd4, 3'd4, 32'hF0000000, 1, 0, "ror4");
    applyStimulus(32'h12345678, 5'd0, 3'd0, 32'h12345678, 0, 0, "sll0");
    applyStimulus(32'h12345678, 5'd31, 3'd7, 32'h12345678, 0, 0, "pass");
    applyStimulus(32'h00000001, 5'd31, 3'd0, 32'h80000000, 8, 5, "bp_sll31");
    applyStimulus(32'hF0F0A5A5, 5'd5, 3'd1, 32'h0787852D, 2, 0, "srl5");

    // Abort during the second SHIFT cycle of a 20-bit SRL.
    @(negedge clk);
    bus.in_a     = 32'hDEADBEEF;
    bus.in_shamt = 5'd20;
    bus.in_op    = 3'd1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
    checkOutput("abort_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_out_r", bus.out_r, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(32'h80000001, 5'd1, 3'd3, 32'h00000003, 1, 0, "rol_after_rst");

    // Sweep every shift amount for each shifting op.
    for (int op = 0; op < 5; op++) begin
      sweepA = $urandom;
      for (s = 0; s < 32; s++) begin
        applyStimulus(sweepA, 5'(s), 3'(op), golden(sweepA, 3'(op), s), modelLat(s, 3'(op)), 0,
                      $sformatf("sweep_op%0d_s%0d", op, s));
      end
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
